// File: rtl/l1_miss_trace_arbiter_pkg.sv
// Shared miss-trace record type and field widths for the L1 miss-trace arbiter.
package l1_miss_trace_arbiter_pkg;
  localparam int PC_W    = 39;
  localparam int SRC_W   = 4;
  localparam int PA_W    = 36;
  localparam int VA_W    = 39;
  localparam int STAMP_W = 64;
  localparam int DROP_W  = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [SRC_W-1:0]   source;
    logic [PA_W-1:0]    paddr;
    logic [VA_W-1:0]    vaddr;
    logic [STAMP_W-1:0] stamp;
  } trace_rec_t;
endpackage

// File: rtl/l1_miss_trace_rr_sel.sv
// Round-robin selector: first valid requester at or above rr_ptr, modulo NUM_REQ.
module l1_miss_trace_rr_sel #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/l1_miss_trace_arbiter.sv
// Round-robin arbiter of L1 miss-trace records into a stamped FIFO feeding the trace writer.
// MISS_TRACE_DROP_EN: never backpressure requesters; records granted while full are counted and dropped.
module l1_miss_trace_arbiter
  import l1_miss_trace_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][PC_W-1:0]    req_pc,
  input  logic [NUM_REQ-1:0][SRC_W-1:0]   req_source,
  input  logic [NUM_REQ-1:0][PA_W-1:0]    req_paddr,
  input  logic [NUM_REQ-1:0][VA_W-1:0]    req_vaddr,
  input  logic                            trace_en,
  input  logic                            dbg_pop_hold,
  output logic                            out_en,
  output logic [PC_W-1:0]                 out_pc,
  output logic [SRC_W-1:0]                out_source,
  output logic [PA_W-1:0]                 out_paddr,
  output logic [VA_W-1:0]                 out_vaddr,
  output logic [STAMP_W-1:0]              out_stamp,
  output logic [DROP_W-1:0]               drop_cnt
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [STAMP_W-1:0] cyc_q, cyc_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  trace_rec_t         mem_q [DEPTH];
  trace_rec_t         push_rec, out_rec;
  logic [NUM_REQ-1:0] sel_valid, sel;
  logic               full, avail, grant_any, push, pop;

  // Full looks only at current occupancy; a same-cycle pop does not free a slot.
  assign full = (count_q == DEPTH_C);
`ifdef MISS_TRACE_DROP_EN
  assign avail = trace_en && !reset;
`else
  assign avail = trace_en && !reset && !full;
`endif
  assign sel_valid = req_valid & {NUM_REQ{avail}};

  l1_miss_trace_rr_sel #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_sel (
    .valid  (sel_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (sel)
  );

  assign req_ready = sel;
  assign grant_any = |sel;
  assign push      = grant_any && !full;
  // dbg_pop_hold freezes the writer side so occupancy can be driven to full.
  assign pop       = (count_q != '0) && !dbg_pop_hold && !reset;

  always_comb begin
    push_rec = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        push_rec.pc     = req_pc[i];
        push_rec.source = req_source[i];
        push_rec.paddr  = req_paddr[i];
        push_rec.vaddr  = req_vaddr[i];
        rr_ptr_d        = (i == NUM_REQ-1) ? '0 : PW'(i+1);
      end
    end
    push_rec.stamp = cyc_q;
    cyc_d    = cyc_q + 64'd1;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cyc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cyc_q    <= cyc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  assign out_rec    = pop ? mem_q[rd_ptr_q] : '0;
  assign out_en     = pop;
  assign out_pc     = out_rec.pc;
  assign out_source = out_rec.source;
  assign out_paddr  = out_rec.paddr;
  assign out_vaddr  = out_rec.vaddr;
  assign out_stamp  = out_rec.stamp;

`ifdef MISS_TRACE_DROP_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (grant_any && full && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_l1_miss_trace_arbiter.sv
// Directed self-checking bench for l1_miss_trace_arbiter (NUM_REQ=4, DEPTH=8).
module tb_l1_miss_trace_arbiter;
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][38:0] req_pc;
  logic [3:0][3:0]  req_source;
  logic [3:0][35:0] req_paddr;
  logic [3:0][38:0] req_vaddr;
  logic             trace_en = 1'b1;
  logic             dbg_pop_hold = 1'b0;
  logic             out_en;
  logic [38:0]      out_pc;
  logic [3:0]       out_source;
  logic [35:0]      out_paddr;
  logic [38:0]      out_vaddr;
  logic [63:0]      out_stamp;
  logic [31:0]      drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  l1_miss_trace_arbiter #(.NUM_REQ(4), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_source(req_source), .req_paddr(req_paddr), .req_vaddr(req_vaddr),
    .trace_en(trace_en), .dbg_pop_hold(dbg_pop_hold), .out_en(out_en), .out_pc(out_pc),
    .out_source(out_source), .out_paddr(out_paddr), .out_vaddr(out_vaddr),
    .out_stamp(out_stamp), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_fields();
    for (int i = 0; i < 4; i++) begin
      req_pc[i]     = 39'h40_0000_1000 + 39'(i);
      req_source[i] = 4'(i + 8);
      req_paddr[i]  = 36'h9_0000_0000 + 36'(i);
      req_vaddr[i]  = 39'h00_1234_0000 + 39'(i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; dbg_pop_hold = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF;
    #1;
    n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_chk++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL reset_out_en: got %b expected 0", out_en); end
    tick(); tick();
    reset = 1'b0; req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL idle_out_en c%0d: got %b expected 0", k, out_en); end
      n_chk++; if (out_stamp !== 64'd0) begin n_fail++; $display("FAIL idle_stamp c%0d: got %h expected 0", k, out_stamp); end
      n_chk++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL idle_drop c%0d: got %0d expected 0", k, drop_cnt); end
      tick();
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (req_ready !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_ready c%0d: got %b expected %b", k, req_ready, 4'(1 << k)); end
      if (k > 0) begin
        n_chk++; if (out_en !== 1'b1 || out_source !== 4'(k + 7) || out_stamp !== 64'(k - 1)) begin
          n_fail++; $display("FAIL rr_out c%0d: got en=%b src=%h stamp=%0d expected en=1 src=%h stamp=%0d", k, out_en, out_source, out_stamp, 4'(k + 7), k - 1);
        end
      end
      tick();
    end
    req_valid = '0;
    #1;
    n_chk++; if (out_en !== 1'b1 || out_source !== 4'hB || out_stamp !== 64'd3 || out_pc !== 39'h40_0000_1003 || out_paddr !== 36'h9_0000_0003) begin
      n_fail++; $display("FAIL rr_last: got en=%b src=%h stamp=%0d pc=%h expected en=1 src=b stamp=3 pc=4000001003", out_en, out_source, out_stamp, out_pc);
    end
    tick(); #1;
    n_chk++; if (out_en !== 1'b0 || out_pc !== 39'd0 || out_stamp !== 64'd0 || out_source !== 4'd0) begin
      n_fail++; $display("FAIL rr_empty: got en=%b pc=%h stamp=%h expected all 0", out_en, out_pc, out_stamp);
    end
    tick();
  endtask

  task automatic test_stamp_match();
    do_reset();
    repeat (16) tick();
    req_pc[2] = 39'h5A_5A5A_5A5A; req_source[2] = 4'hC; req_valid = 4'b0100;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL stamp_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_chk++; if (out_en !== 1'b1 || out_source !== 4'hC || out_pc !== 39'h5A_5A5A_5A5A || out_vaddr !== 39'h00_1234_0002 || out_stamp !== 64'h10) begin
      n_fail++; $display("FAIL stamp_out: got en=%b src=%h pc=%h stamp=%h expected en=1 src=c pc=5a5a5a5a5a stamp=10", out_en, out_source, out_pc, out_stamp);
    end
    tick();
    set_fields();
  endtask

  task automatic fill_held();
    do_reset();
    dbg_pop_hold = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_chk++; if (req_ready !== 4'(1 << (k % 4)) || out_en !== 1'b0) begin
        n_fail++; $display("FAIL fill c%0d: got ready=%b en=%b expected ready=%b en=0", k, req_ready, out_en, 4'(1 << (k % 4)));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    fill_held();
    #1;
    n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL full_ready: got %b expected 0000", req_ready); end
    tick();
    dbg_pop_hold = 1'b0;
    #1;
    n_chk++; if (req_ready !== 4'h0 || out_en !== 1'b1 || out_source !== 4'h8 || out_stamp !== 64'd0) begin
      n_fail++; $display("FAIL full_pop: got ready=%b en=%b src=%h stamp=%0d expected ready=0000 en=1 src=8 stamp=0", req_ready, out_en, out_source, out_stamp);
    end
    tick(); #1;
    n_chk++; if (req_ready !== 4'b0001 || out_source !== 4'h9 || out_stamp !== 64'd1) begin
      n_fail++; $display("FAIL resume: got ready=%b src=%h stamp=%0d expected ready=0001 src=9 stamp=1", req_ready, out_source, out_stamp);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_chk++; if (out_en !== 1'b1 || out_source !== 4'(((k + 2) % 4) + 8) || out_stamp !== 64'((k < 6) ? k + 2 : 10)) begin
        n_fail++; $display("FAIL drain c%0d: got en=%b src=%h stamp=%0d expected en=1 src=%h stamp=%0d", k, out_en, out_source, out_stamp, 4'(((k + 2) % 4) + 8), (k < 6) ? k + 2 : 10);
      end
      tick();
    end
    #1;
    n_chk++; if (out_en !== 1'b0 || drop_cnt !== 32'd0) begin n_fail++; $display("FAIL drain_end: got en=%b drop=%0d expected en=0 drop=0", out_en, drop_cnt); end
    tick();
  endtask

  task automatic test_drop();
    fill_held();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (req_ready !== 4'(1 << k)) begin n_fail++; $display("FAIL drop_ready c%0d: got %b expected %b", k, req_ready, 4'(1 << k)); end
      tick();
    end
    #1;
    n_chk++; if (drop_cnt !== 32'd3) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 3", drop_cnt); end
    req_valid = '0; dbg_pop_hold = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (out_en !== 1'b1 || out_source !== 4'((k % 4) + 8) || out_stamp !== 64'(k)) begin
        n_fail++; $display("FAIL drop_drain c%0d: got en=%b src=%h stamp=%0d expected en=1 src=%h stamp=%0d", k, out_en, out_source, out_stamp, 4'((k % 4) + 8), k);
      end
      tick(); #1;
    end
    n_chk++; if (out_en !== 1'b0 || drop_cnt !== 32'd3) begin n_fail++; $display("FAIL drop_end: got en=%b drop=%0d expected en=0 drop=3", out_en, drop_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dbg_pop_hold = 1'b1; req_valid = 4'hF;
    repeat (5) tick();
    req_valid = 4'b0010; reset = 1'b1;
    #1;
    n_chk++; if (out_en !== 1'b0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_mid_hi: got en=%b ready=%b expected en=0 ready=0000", out_en, req_ready); end
    tick();
    dbg_pop_hold = 1'b0; reset = 1'b0;
    #1;
    n_chk++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flush: got en=%b expected 0", out_en); end
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_chk++; if (out_en !== 1'b1 || out_source !== 4'h9 || out_stamp !== 64'd0) begin
      n_fail++; $display("FAIL rst_mid_first: got en=%b src=%h stamp=%0d expected en=1 src=9 stamp=0", out_en, out_source, out_stamp);
    end
    tick(); #1;
    n_chk++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dup: got en=%b expected 0", out_en); end
    tick();
  endtask

  initial begin
    set_fields();
    @(negedge clock);
    test_reset();
    test_rr_order();
    test_stamp_match();
`ifdef MISS_TRACE_DROP_EN
    test_drop();
`else
    test_backpressure();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
